// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_responder
// Description : Byte-wide memory/IO responder for the CPU memory bus.
//               Provides a byte-addressable synchronous RAM, a UART TX FIFO
//               with near-full backpressure, a halt register and, when the
//               UART_RX_EN macro is defined, a UART RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt,
    output logic [7:0]  halt_code
);

    localparam int               TX_AW       = $clog2(TX_DEPTH);
    localparam logic [17:0]      C_UART_DATA = 18'h30000;
    localparam logic [17:0]      C_UART_STAT = 18'h30004;
    localparam logic [TX_AW:0]   C_TX_FULL   = (TX_AW+1)'(TX_DEPTH);
    localparam logic [TX_AW:0]   C_TX_NEAR   = (TX_AW+1)'(TX_DEPTH - 1);

    // Only the low 18 address bits take part in decoding.
    logic w_unused_addr;
    assign w_unused_addr = ^mem_a[31:18];

    logic                  w_is_io, w_is_data, w_is_stat;
    logic                  w_ram_wr, w_stat_rd, w_data_rd;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic [7:0]            w_ram_rd, w_rd_data, w_status, w_rx_head;
    logic                  w_rx_nonempty;

    assign w_is_io   = (mem_a[17:16] == 2'b11);
    assign w_is_data = (mem_a[17:0] == C_UART_DATA);
    assign w_is_stat = (mem_a[17:0] == C_UART_STAT);
    assign w_ram_idx = mem_a[ADDR_WIDTH-1:0];
    assign w_ram_wr  = mem_wr && !w_is_io;
    assign w_stat_rd = !mem_wr && w_is_stat;
    assign w_data_rd = !mem_wr && w_is_data;

    // ---------------------------------------------------------------- RAM
    logic [7:0] r_ram [2**ADDR_WIDTH];

    // RAM write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_wr) r_ram[w_ram_idx] <= mem_dout;
    end
    assign w_ram_rd = r_ram[w_ram_idx];

    // ------------------------------------------------------------ TX FIFO
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wptr, r_tx_rptr;
    logic [TX_AW:0]   r_tx_count;
    logic             r_tx_ovf;
    logic             w_tx_req, w_tx_push, w_tx_drop, w_tx_pop;

    assign w_tx_req       = mem_wr && w_is_data;
    assign w_tx_drop      = w_tx_req && (r_tx_count == C_TX_FULL);
    assign w_tx_push      = w_tx_req && !w_tx_drop;
    assign tx_valid       = (r_tx_count != '0);
    assign w_tx_pop       = tx_valid && tx_ready;
    assign tx_data        = r_tx_mem[r_tx_rptr];
    assign io_buffer_full = (r_tx_count >= C_TX_NEAR);

    // TX storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= mem_dout;
    end

    // TX pointers, occupancy and sticky overflow (set wins over status-read clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_tx_ovf   <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
            if (w_tx_drop)      r_tx_ovf <= 1'b1;
            else if (w_stat_rd) r_tx_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------ RX FIFO
`ifdef UART_RX_EN
    localparam int             RX_AW     = $clog2(RX_DEPTH);
    localparam logic [RX_AW:0] C_RX_FULL = (RX_AW+1)'(RX_DEPTH);

    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wptr, r_rx_rptr;
    logic [RX_AW:0]   r_rx_count;
    logic             w_rx_push, w_rx_pop;

    assign rx_ready      = (r_rx_count != C_RX_FULL);
    assign w_rx_nonempty = (r_rx_count != '0);
    assign w_rx_push     = rx_valid && rx_ready;
    assign w_rx_pop      = w_data_rd && w_rx_nonempty;
    assign w_rx_head     = w_rx_nonempty ? r_rx_mem[r_rx_rptr] : 8'h00;

    // RX storage write.
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data;
    end

    // RX pointers and occupancy; a bus read of the data register pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end
`else
    logic w_unused_rx;
    assign w_unused_rx   = ^{rx_data, rx_valid, w_data_rd};
    assign rx_ready      = 1'b0;
    assign w_rx_nonempty = 1'b0;
    assign w_rx_head     = 8'h00;
`endif

    // --------------------------------------------------------- read path
    assign w_status = {5'b0, r_tx_ovf, w_rx_nonempty, io_buffer_full};

    // Select the byte returned for the current read address.
    always_comb begin
        w_rd_data = 8'h00;
        if (!w_is_io)       w_rd_data = w_ram_rd;
        else if (w_is_data) w_rd_data = w_rx_head;
        else if (w_is_stat) w_rd_data = w_status;
    end

    logic [7:0] r_din;
    logic       r_halt;
    logic [7:0] r_halt_code;

    // Registered read data (held on writes) and the halt pulse/code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din       <= 8'h00;
            r_halt      <= 1'b0;
            r_halt_code <= 8'h00;
        end else begin
            if (!mem_wr) r_din <= w_rd_data;
            r_halt <= mem_wr && w_is_stat;
            if (mem_wr && w_is_stat) r_halt_code <= mem_dout;
        end
    end

    assign mem_din   = r_din;
    assign halt      = r_halt;
    assign halt_code = r_halt_code;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_bus_responder
// Description : Self-checking bench for mem_bus_responder: directed scenarios
//               plus random bus traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

    localparam int AW  = 17;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        halt;
    logic [7:0]  halt_code;

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_WIDTH(AW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .rst_n(rst_n), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .halt(halt), .halt_code(halt_code)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ------------------------------------------------ reference model state
    logic [7:0] m_ram [int];
    logic [7:0] q_tx [$];
    logic [7:0] q_rx [$];
    logic [7:0] e_din;
    bit         e_din_known;
    bit         e_ovf;
    bit         e_halt;
    logic [7:0] e_code;

    task automatic model_reset();
        q_tx.delete();
        q_rx.delete();
        e_din = 8'h00; e_din_known = 1'b1;
        e_ovf = 1'b0; e_halt = 1'b0; e_code = 8'h00;
    endtask

    // One bus cycle worth of behaviour, from the pre-edge state and inputs.
    task automatic model_edge(input logic [31:0] a, input bit wr, input logic [7:0] d,
                              input bit txr, input bit rxv, input logic [7:0] rxd);
        logic [17:0] la;
        bit          io, set_ovf;
        logic [7:0]  stat;
        int          idx;
        la   = a[17:0];
        io   = (la[17:16] == 2'b11);
        idx  = int'(a[AW-1:0]);
        stat = {5'b0, e_ovf, (q_rx.size() != 0), (q_tx.size() >= TXD - 1)};
        if (!wr) begin
            e_din_known = 1'b1;
            if (!io) begin
                if (m_ram.exists(idx)) e_din = m_ram[idx];
                else e_din_known = 1'b0;
            end else if (la == 18'h30000) begin
`ifdef UART_RX_EN
                e_din = (q_rx.size() != 0) ? q_rx[0] : 8'h00;
`else
                e_din = 8'h00;
`endif
            end else if (la == 18'h30004) e_din = stat;
            else e_din = 8'h00;
        end
        e_halt = wr && (la == 18'h30004);
        if (e_halt) e_code = d;
        set_ovf = wr && (la == 18'h30000) && (q_tx.size() == TXD);
        if (set_ovf) e_ovf = 1'b1;
        else if (!wr && la == 18'h30004) e_ovf = 1'b0;
        if (q_tx.size() != 0 && txr) void'(q_tx.pop_front());
        if (wr && la == 18'h30000 && !set_ovf) q_tx.push_back(d);
`ifdef UART_RX_EN
        begin
            bit rpop, rpush;
            rpop  = !wr && (la == 18'h30000) && (q_rx.size() != 0);
            rpush = rxv && (q_rx.size() != RXD);
            if (rpop) void'(q_rx.pop_front());
            if (rpush) q_rx.push_back(rxd);
        end
`else
        if (rxv && rxd == 8'hFF) idx = idx; // RX inputs have no effect here
`endif
        if (wr && !io) m_ram[idx] = d;
    endtask

    task automatic compare_all();
        if (e_din_known) check_eq("mem_din", mem_din, e_din);
        check_eq("tx_valid", tx_valid, q_tx.size() != 0);
        if (q_tx.size() != 0) check_eq("tx_data", tx_data, q_tx[0]);
        check_eq("io_buffer_full", io_buffer_full, q_tx.size() >= TXD - 1);
        check_eq("halt", halt, e_halt);
        check_eq("halt_code", halt_code, e_code);
`ifdef UART_RX_EN
        check_eq("rx_ready", rx_ready, q_rx.size() != RXD);
`else
        check_eq("rx_ready", rx_ready, 1'b0);
`endif
    endtask

    // Drive one bus cycle, advance past the edge, then compare against the model.
    task automatic step(input logic [31:0] a, input bit wr, input logic [7:0] d);
        mem_a = a; mem_wr = wr; mem_dout = d;
        @(posedge clk);
        model_edge(a, wr, d, tx_ready, rx_valid, rx_data);
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_eq("rst_mem_din", mem_din, 8'h00);
        check_eq("rst_tx_valid", tx_valid, 1'b0);
        check_eq("rst_io_full", io_buffer_full, 1'b0);
        check_eq("rst_halt", halt, 1'b0);
        check_eq("rst_halt_code", halt_code, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // RAM write then back-to-back reads
        for (int i = 0; i < 4; i++) step(32'h100 + i, 1'b1, 8'h11 * (i + 1));
        for (int i = 0; i < 4; i++) begin
            step(32'h100 + i, 1'b0, 8'h00);
            check_eq("ram_rd_const", mem_din, 8'h11 * (i + 1));
        end
        step(32'h200, 1'b1, 8'h9C);
        step(32'h200, 1'b0, 8'h00);
        check_eq("ram_raw", mem_din, 8'h9C);

        // TX backpressure and overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(32'h30000, 1'b1, 8'h41 + i);
            if (i == 6) check_eq("full_after_7", io_buffer_full, 1'b1);
        end
        step(32'h30004, 1'b0, 8'h00);
        check_eq("status_ovf", mem_din, 8'h05);
        step(32'h30004, 1'b0, 8'h00);
        check_eq("status_clr", mem_din, 8'h01);
        check_eq("tx_head", tx_data, 8'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(32'h0, 1'b0, 8'h00);

        // TX concurrency: push with pop at count 3, then a long stream
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(32'h30000, 1'b1, 8'h60 + i);
        tx_ready = 1'b1;
        step(32'h30000, 1'b1, 8'h63);
        check_eq("conc_count3", q_tx.size(), 3);
        for (int i = 0; i < 20; i++) step(32'h30000, 1'b1, 8'h80 + i);
        for (int i = 0; i < 6; i++) step(32'h30004, 1'b0, 8'h00);
        check_eq("no_ovf", mem_din[2], 1'b0);

        // Halt pulse
        step(32'h30004, 1'b1, 8'h2A);
        check_eq("halt_hi", halt, 1'b1);
        check_eq("halt_code_2a", halt_code, 8'h2A);
        step(32'h0, 1'b0, 8'h00);
        check_eq("halt_lo", halt, 1'b0);

        // RX path
        rx_valid = 1'b1; rx_data = 8'h55;
        step(32'h0, 1'b0, 8'h00);
        rx_data = 8'h66;
        step(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        step(32'h30004, 1'b0, 8'h00);
        step(32'h30001, 1'b0, 8'h00);
        check_eq("rx_neighbour", mem_din, 8'h00);
        for (int i = 0; i < 3; i++) step(32'h30000, 1'b0, 8'h00);
`ifdef UART_RX_EN
        check_eq("rx_third", mem_din, 8'h00);
`else
        check_eq("rx_disabled", mem_din, 8'h00);
`endif

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0, 1, 2, 3: a = 32'($urandom_range(0, 15));
                4, 7:       a = 32'h30000;
                5:          a = 32'h30004;
                default:    a = ($urandom_range(0, 1) != 0) ? 32'h30001 : 32'h30008;
            endcase
            tx_ready = ($urandom_range(0, 3) != 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            step(a, $urandom_range(0, 1) != 0, 8'($urandom));
        end
        rx_valid = 1'b0;

        // Asynchronous reset mid-operation
        tx_ready = 1'b0;
        step(32'h50, 1'b1, 8'hA5);
        step(32'h0, 1'b0, 8'h00);
        step(32'h30000, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(32'h30000, 1'b1, 8'hC0 + i);
        step(32'h30004, 1'b1, 8'h77);
        check_eq("pre_rst_halt", halt, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_tx_valid", tx_valid, 1'b0);
        check_eq("arst_io_full", io_buffer_full, 1'b0);
        check_eq("arst_halt", halt, 1'b0);
        check_eq("arst_mem_din", mem_din, 8'h00);
        mem_wr = 1'b0; mem_a = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h50, 1'b0, 8'h00);
        check_eq("ram_after_rst", mem_din, 8'hA5);
        step(32'h100, 1'b0, 8'h00);
        check_eq("ram_after_rst2", mem_din, 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
